genie_wrr_merge_ctl: RTL

Packet-aware weighted round-robin controller for an NI-input merge point. It decides which input owns the shared output and drives the select for an external data mux, the per-input readies, and the muxed valid/eop. Each input, once granted, keeps ownership for up to a configurable number of whole packets per turn before ownership rotates. It sits between NI ready/valid packet sources and one downstream sink, beside the data mux it steers.

---
 rtl/genie_wrr_merge_ctl.sv | 113 +++++++++++
 1 files changed

// File: rtl/genie_wrr_merge_ctl.sv
// Packet-aware weighted round-robin owner select for an NI-input merge point.
// Latency: zero -- o_sel/o_valid/o_eop/o_ready are combinational from inputs and registered owner state.
// Backpressure: i_ready gates every o_ready bit; state only moves on a transfer (o_valid && i_ready).
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   i_valid, i_eop   per-input valid and end-of-packet (eop qualified by valid)
//   i_weight         per-input packets-per-turn, WBITS each, 0 treated as 1
//   i_ready          downstream ready
//   o_sel            data-mux select (index of the input steered to the output)
//   o_valid, o_eop   valid/eop of the selected input
//   o_ready          per-input ready, only the selected input may see it
//   o_locked         registered mid-packet flag
module genie_wrr_merge_ctl #(
    parameter int NI    = 2,
    parameter int WBITS = 4,
    localparam int NIBITS = (NI > 1) ? $clog2(NI) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NI-1:0]       i_valid,
    input  logic [NI-1:0]       i_eop,
    output logic [NI-1:0]       o_ready,
    input  logic [NI*WBITS-1:0] i_weight,
    output logic [NIBITS-1:0]   o_sel,
    output logic                o_valid,
    output logic                o_eop,
    input  logic                i_ready,
    output logic                o_locked
);

    logic [NIBITS-1:0] owner_q, owner_d;
    logic [WBITS-1:0]  credit_q, credit_d;
    logic              locked_q, locked_d;

    logic              hold;
    logic              found;
    logic [NIBITS-1:0] rr_pick;
    logic [NIBITS-1:0] cand;
    logic [NIBITS-1:0] sel;
    logic [WBITS-1:0]  sel_w;
    logic [WBITS-1:0]  eff_w;
    logic              xfer;

    // Arbitration and output steering.
    always_comb begin
        // Another packet in the current turn: owner still has credit and is
        // presenting a packet start right now.
        hold = !locked_q && (credit_q != '0) && i_valid[owner_q];

        // Scan starts one past the owner and ends on the owner itself, so the
        // owner is the lowest-priority candidate when its turn is over.
        rr_pick = owner_q;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NI; k++) begin
            cand = NIBITS'((int'(owner_q) + k) % NI);
            if (!found && i_valid[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end

        sel     = (locked_q || hold) ? owner_q : rr_pick;
        o_sel   = sel;
        o_valid = i_valid[sel];
        o_eop   = i_eop[sel];

        o_ready = '0;
        sel_w   = '0;
        for (int i = 0; i < NI; i++) begin
            o_ready[i] = i_ready && (sel == NIBITS'(i));
            if (sel == NIBITS'(i)) begin
                sel_w = i_weight[i*WBITS +: WBITS];
            end
        end
        eff_w = (sel_w == '0) ? WBITS'(1) : sel_w;
        xfer  = o_valid && i_ready;
    end

    // Next state: only a transfer moves ownership, credit or the packet lock.
    always_comb begin
        owner_d  = owner_q;
        credit_d = credit_q;
        locked_d = locked_q;
        if (xfer) begin
            locked_d = !o_eop;
            if (!locked_q && !hold) begin
                // Turn start: the weight is sampled only here, so weight
                // changes mid-turn take effect at the next turn.
                owner_d  = sel;
                credit_d = eff_w - WBITS'(1);
            end else if (hold) begin
                credit_d = credit_q - WBITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= '0;
            credit_q <= '0;
            locked_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            credit_q <= credit_d;
            locked_q <= locked_d;
        end
    end

    assign o_locked = locked_q;

endmodule
